// File: rtl/bcd_stopwatch_mux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : bcd_stopwatch_mux
//  Description : Multi-digit BCD stopwatch / countdown timer with a
//                time-multiplexed, active-low seven-segment display driver.
//                A RUNNING/STOPPED/EXPIRED state machine gates a prescaler
//                that produces the count tick; the scan logic runs freely.
//  Ports       : clk        - single clock, rising edge
//                reset      - synchronous active-low reset
//                start_stop - pulse: toggle run/pause (ignored when expired)
//                clear      - pulse: zero the count and stop
//                load       - pulse: preset count from load_val and stop
//                load_val   - BCD preset, digit 0 in bits [3:0]
//                up_down    - 1 = count up, 0 = count down
//                count_bcd  - registered BCD count
//                running    - high while counting
//                tc         - one-cycle registered terminal-count pulse
//                seg        - active-low segments {g,f,e,d,c,b,a}
//                AN         - active-low one-hot digit enables
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_stopwatch_mux #(
    parameter int CLK_HZ  = 100000000,
    parameter int TICK_HZ = 1,
    parameter int DIGITS  = 4,
    parameter int SCAN_HZ = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_stop,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  up_down,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  running,
    output logic                  tc,
    output logic [6:0]            seg,
    output logic [7:0]            AN
);

    localparam int c_TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int c_PRESC_W  = $clog2(c_TICK_DIV);
    localparam int c_SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int c_SCAN_W   = $clog2(c_SCAN_DIV);
    localparam int c_IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(c_TICK_DIV - 1);
    localparam logic [c_SCAN_W-1:0]  c_SCAN_LAST  = c_SCAN_W'(c_SCAN_DIV - 1);
    localparam logic [c_IDX_W-1:0]   c_IDX_LAST   = c_IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_STOPPED = 2'd0,
        S_RUNNING = 2'd1,
        S_EXPIRED = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [4*DIGITS-1:0]    r_count;
    logic [4*DIGITS-1:0]    w_count_nxt;
    logic [c_PRESC_W-1:0]   r_presc;
    logic [c_PRESC_W-1:0]   w_presc_nxt;
    logic                   r_tc;
    logic                   w_tc_nxt;
    logic [c_SCAN_W-1:0]    r_scan_cnt;
    logic [c_IDX_W-1:0]     r_scan_idx;
    logic [6:0]             r_seg;
    logic [7:0]             r_an;

    logic [4*DIGITS-1:0]    w_inc;
    logic [4*DIGITS-1:0]    w_dec;
    logic [4*DIGITS-1:0]    w_load_sat;
    logic                   w_carry;
    logic                   w_borrow;
    logic                   w_all_nines;
    logic                   w_tick;
    logic [3:0]             w_digit;
    logic [7:0]             w_an;

    function automatic logic [6:0] f_seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // BCD increment/decrement with a single ripple across all digits, plus
    // per-digit saturation of the preset value.
    always_comb begin
        w_inc      = r_count;
        w_dec      = r_count;
        w_load_sat = load_val;
        w_carry    = 1'b1;
        w_borrow   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_carry) begin
                if (r_count[4*i +: 4] == 4'd9) begin
                    w_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                    w_carry         = 1'b0;
                end
            end
            if (w_borrow) begin
                if (r_count[4*i +: 4] == 4'd0) begin
                    w_dec[4*i +: 4] = 4'd9;
                end else begin
                    w_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
                    w_borrow        = 1'b0;
                end
            end
            if (load_val[4*i +: 4] > 4'd9) begin
                w_load_sat[4*i +: 4] = 4'd9;
            end
        end
        // Carry out of the top digit means every digit was 9.
        w_all_nines = w_carry;
    end

    assign w_tick = (r_state == S_RUNNING) && (r_presc == c_PRESC_LAST);

    // Next-state logic; the if/else chain encodes the input priority
    // clear > load > start_stop > tick.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_presc_nxt = r_presc;
        w_tc_nxt    = 1'b0;
        if (clear) begin
            w_state_nxt = S_STOPPED;
            w_count_nxt = '0;
            w_presc_nxt = '0;
        end else if (load) begin
            w_state_nxt = S_STOPPED;
            w_count_nxt = w_load_sat;
            w_presc_nxt = '0;
        end else if (start_stop && (r_state != S_EXPIRED)) begin
            if (r_state == S_STOPPED) begin
                w_state_nxt = S_RUNNING;
                w_presc_nxt = '0;
            end else begin
                w_state_nxt = S_STOPPED;
            end
        end else if (r_state == S_RUNNING) begin
            if (w_tick) begin
                w_presc_nxt = '0;
                if (up_down) begin
                    w_count_nxt = w_inc;
                    w_tc_nxt    = w_all_nines;
                end else if (r_count == '0) begin
                    // Started from zero in down mode: expire without wrapping.
                    w_tc_nxt    = 1'b1;
                    w_state_nxt = S_EXPIRED;
                end else begin
                    w_count_nxt = w_dec;
                    if (w_dec == '0) begin
                        w_tc_nxt    = 1'b1;
                        w_state_nxt = S_EXPIRED;
                    end
                end
            end else begin
                w_presc_nxt = r_presc + c_PRESC_W'(1);
            end
        end
    end

    // Digit currently being scanned and its enable pattern.
    always_comb begin
        w_digit = r_count[3:0];
        for (int i = 0; i < DIGITS; i++) begin
            if (r_scan_idx == c_IDX_W'(i)) begin
                w_digit = r_count[4*i +: 4];
            end
        end
        w_an = ~(8'd1 << r_scan_idx);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_STOPPED;
            r_count    <= '0;
            r_presc    <= '0;
            r_tc       <= 1'b0;
            r_scan_cnt <= '0;
            r_scan_idx <= '0;
            r_seg      <= 7'b1000000;
            r_an       <= 8'b11111110;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_presc <= w_presc_nxt;
            r_tc    <= w_tc_nxt;
            if (r_scan_cnt == c_SCAN_LAST) begin
                r_scan_cnt <= '0;
                r_scan_idx <= (r_scan_idx == c_IDX_LAST) ? '0 : r_scan_idx + c_IDX_W'(1);
            end else begin
                r_scan_cnt <= r_scan_cnt + c_SCAN_W'(1);
            end
            r_seg <= f_seg7(w_digit);
            r_an  <= w_an;
        end
    end

    assign count_bcd = r_count;
    assign running   = (r_state == S_RUNNING);
    assign tc        = r_tc;
    assign seg       = r_seg;
    assign AN        = r_an;

endmodule
`default_nettype wire

// File: tb/tb_bcd_stopwatch_mux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_stopwatch_mux
//  Description : Self-checking bench for bcd_stopwatch_mux with a
//                behavioural integer model compared every cycle, plus
//                directed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_stopwatch_mux;

    localparam int CLK_HZ   = 20;
    localparam int TICK_HZ  = 2;
    localparam int SCAN_HZ  = 5;
    localparam int DIGITS   = 2;
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;

    logic       clk        = 1'b0;
    logic       reset      = 1'b0;
    logic       start_stop = 1'b0;
    logic       clear      = 1'b0;
    logic       load       = 1'b0;
    logic [7:0] load_val   = 8'h00;
    logic       up_down    = 1'b1;
    logic [7:0] count_bcd;
    logic       running;
    logic       tc;
    logic [6:0] seg;
    logic [7:0] AN;

    bcd_stopwatch_mux #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .DIGITS  (DIGITS),
        .SCAN_HZ (SCAN_HZ)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_stop (start_stop),
        .clear      (clear),
        .load       (load),
        .load_val   (load_val),
        .up_down    (up_down),
        .count_bcd  (count_bcd),
        .running    (running),
        .tc         (tc),
        .seg        (seg),
        .AN         (AN)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic logic [7:0] to_bcd(input int n);
        return 8'(((n / 10) * 16) + (n % 10));
    endfunction

    function automatic int sat_val(input logic [7:0] v);
        int hi;
        int lo;
        hi = (int'(v[7:4]) > 9) ? 9 : int'(v[7:4]);
        lo = (int'(v[3:0]) > 9) ? 9 : int'(v[3:0]);
        return hi * 10 + lo;
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model: count as a plain integer 0..99
    // ------------------------------------------------------------------
    int         m_count   = 0;
    bit         m_run     = 1'b0;
    bit         m_expired = 1'b0;
    int         m_presc   = 0;
    bit         m_tc      = 1'b0;
    int         m_since   = 0;
    logic [7:0] m_an      = 8'hFE;
    logic [6:0] m_seg     = 7'b1000000;
    bit         chk_en    = 1'b0;

    always @(posedge clk) begin : model
        int idx;
        int digit;
        idx   = (m_since / SCAN_DIV) % DIGITS;
        digit = (idx == 0) ? (m_count % 10) : ((m_count / 10) % 10);
        m_an  = ~(8'h01 << idx);
        m_seg = seg_of(digit);
        if (!reset) begin
            m_count   = 0;
            m_run     = 1'b0;
            m_expired = 1'b0;
            m_presc   = 0;
            m_tc      = 1'b0;
            m_since   = 0;
            m_an      = 8'hFE;
            m_seg     = 7'b1000000;
        end else begin
            m_since++;
            m_tc = 1'b0;
            if (clear) begin
                m_count = 0; m_run = 1'b0; m_expired = 1'b0; m_presc = 0;
            end else if (load) begin
                m_count = sat_val(load_val); m_run = 1'b0; m_expired = 1'b0; m_presc = 0;
            end else if (start_stop && !m_expired) begin
                if (m_run) m_run = 1'b0;
                else begin
                    m_run   = 1'b1;
                    m_presc = 0;
                end
            end else if (m_run) begin
                if (m_presc == TICK_DIV - 1) begin
                    m_presc = 0;
                    if (up_down) begin
                        if (m_count == 99) begin
                            m_count = 0;
                            m_tc    = 1'b1;
                        end else m_count++;
                    end else if (m_count <= 1) begin
                        m_count   = 0;
                        m_tc      = 1'b1;
                        m_run     = 1'b0;
                        m_expired = 1'b1;
                    end else m_count--;
                end else m_presc++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_count", 32'(count_bcd), 32'(to_bcd(m_count)));
            check("model_running", 32'(running), 32'(m_run));
            check("model_tc", 32'(tc), 32'(m_tc));
            check("model_AN", 32'(AN), 32'(m_an));
            check("model_seg", 32'(seg), 32'(m_seg));
        end
    end

    int tc_seen   = 0;
    int run_drop  = 0;
    bit watch_run = 1'b0;
    always @(posedge clk) begin
        tc_seen += int'(tc);
        if (watch_run && !running) run_drop++;
    end

    task automatic do_pulse(input bit p_ss, input bit p_clr, input bit p_ld);
        start_stop = p_ss;
        clear      = p_clr;
        load       = p_ld;
        @(negedge clk);
        start_stop = 1'b0;
        clear      = 1'b0;
        load       = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset held low for two edges
        reset = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_count", 32'(count_bcd), 32'h00);
        check("rst_running", 32'(running), 32'h0);
        check("rst_tc", 32'(tc), 32'h0);
        check("rst_AN", 32'(AN), 32'hFE);
        check("rst_seg", 32'(seg), 32'h40);
        reset = 1'b1;
        wait_cyc(3);

        // Count up: first tick latency, then 100 ticks wrap with one tc
        up_down = 1'b1;
        tc_seen = 0;
        run_drop = 0;
        do_pulse(1'b1, 1'b0, 1'b0);
        watch_run = 1'b1;
        wait_cyc(9);
        check("up_before_first_tick", 32'(count_bcd), 32'h00);
        wait_cyc(1);
        check("up_first_tick", 32'(count_bcd), 32'h01);
        wait_cyc(990);
        check("up_wrap_count", 32'(count_bcd), 32'h00);
        check("up_wrap_tc", 32'(tc), 32'h1);
        check("up_wrap_running", 32'(running), 32'h1);
        wait_cyc(2);
        check("up_tc_once", 32'(tc_seen), 32'd1);
        watch_run = 1'b0;
        check("up_running_throughout", 32'(run_drop), 32'd0);

        // Clear and start_stop together while running
        wait_cyc(33);
        check("up_count_03", 32'(count_bcd), 32'h03);
        do_pulse(1'b1, 1'b1, 1'b0);
        check("clr_ss_count", 32'(count_bcd), 32'h00);
        check("clr_ss_running", 32'(running), 32'h0);
        wait_cyc(25);
        check("clr_ss_no_tick", 32'(count_bcd), 32'h00);

        // Countdown from 03 to expiry
        load_val = 8'h03;
        up_down  = 1'b0;
        do_pulse(1'b0, 1'b0, 1'b1);
        check("load03", 32'(count_bcd), 32'h03);
        do_pulse(1'b1, 1'b0, 1'b0);
        wait_cyc(10);
        check("down_02", 32'(count_bcd), 32'h02);
        wait_cyc(10);
        check("down_01", 32'(count_bcd), 32'h01);
        wait_cyc(10);
        check("down_00", 32'(count_bcd), 32'h00);
        check("down_tc", 32'(tc), 32'h1);
        check("down_expired_running", 32'(running), 32'h0);
        wait_cyc(1);
        check("down_tc_single", 32'(tc), 32'h0);
        do_pulse(1'b1, 1'b0, 1'b0);
        wait_cyc(20);
        check("expired_ss_ignored", 32'(running), 32'h0);
        check("expired_count_hold", 32'(count_bcd), 32'h00);

        // Down from zero: tc and expire without wrap
        do_pulse(1'b0, 1'b1, 1'b0);
        do_pulse(1'b1, 1'b0, 1'b0);
        check("zero_start_running", 32'(running), 32'h1);
        wait_cyc(10);
        check("zero_down_tc", 32'(tc), 32'h1);
        check("zero_down_running", 32'(running), 32'h0);
        check("zero_down_count", 32'(count_bcd), 32'h00);

        // Load saturation
        load_val = 8'h3C;
        do_pulse(1'b0, 1'b0, 1'b1);
        check("load_3C", 32'(count_bcd), 32'h39);
        check("load_3C_running", 32'(running), 32'h0);
        load_val = 8'hA5;
        do_pulse(1'b0, 1'b0, 1'b1);
        check("load_A5", 32'(count_bcd), 32'h95);

        // Direction change between ticks takes effect at the tick
        load_val = 8'h50;
        do_pulse(1'b0, 1'b0, 1'b1);
        up_down = 1'b1;
        do_pulse(1'b1, 1'b0, 1'b0);
        wait_cyc(5);
        up_down = 1'b0;
        wait_cyc(5);
        check("dir_change", 32'(count_bcd), 32'h49);

        // Reset mid-count
        wait_cyc(4);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_count", 32'(count_bcd), 32'h00);
        check("midrst_running", 32'(running), 32'h0);
        check("midrst_AN", 32'(AN), 32'hFE);
        reset = 1'b1;

        // Reset landing on the edge that would emit tc
        load_val = 8'h01;
        do_pulse(1'b0, 1'b0, 1'b1);
        do_pulse(1'b1, 1'b0, 1'b0);
        wait_cyc(9);
        reset = 1'b0;
        @(negedge clk);
        check("rst_on_tick_tc", 32'(tc), 32'h0);
        check("rst_on_tick_count", 32'(count_bcd), 32'h00);
        reset = 1'b1;
        wait_cyc(15);
        check("rst_on_tick_stopped", 32'(running), 32'h0);

        // Reset from EXPIRED, then start runs again
        do_pulse(1'b0, 1'b0, 1'b1);
        do_pulse(1'b1, 1'b0, 1'b0);
        wait_cyc(10);
        check("exp_before_rst", 32'(running), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        do_pulse(1'b1, 1'b0, 1'b0);
        check("restart_after_rst", 32'(running), 32'h1);
        do_pulse(1'b1, 1'b0, 1'b0);

        // Scan with count 42
        load_val = 8'h42;
        do_pulse(1'b0, 1'b0, 1'b1);
        wait_cyc(4);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (AN == 8'hFE) begin
                check("scan_seg_d0", 32'(seg), 32'(7'b0100100));
            end else begin
                check("scan_AN_d1", 32'(AN), 32'hFD);
                check("scan_seg_d1", 32'(seg), 32'(7'b0011001));
            end
        end

        wait_cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
